jtframe_ba_sched: RTL and testbench
===================================

# jtframe_ba_sched

Round-robin scheduler that shares one SDRAM bank port (ba_addr/ba_rd/ba_wr/ba_dst/ba_dok/ba_rdy/ba_ack) among SLOTS game-side requesters.
- Sits between the game-side memory slots and the jtframe SDRAM controller bank interface, one instance per bank.
- Serialises requests, holds address and data stable until the controller acknowledges, and routes dst/dok/rdy back to the owning slot.
- Blocks new grants while a ROM download owns the SDRAM, and recovers from a stalled controller with a watchdog.

## Interface
- SLOTS, 4, number of requesters (2..8)
- AW, 22, SDRAM word-address width (SDRAMW)
- TOUT, 255, watchdog limit in clk cycles after ba_ack with no ba_rdy
- clk  in  1  system/SDRAM clock (clk_rom domain)
- rst_n  in  1  synchronous, active-low reset
- downloading  in  1  high: no new grants
- slot_req  in  SLOTS  request, held high until the slot's slot_rdy or slot_err
- slot_we  in  SLOTS  1 = write, 0 = read; sampled at grant
- slot_addr  in  SLOTS*AW  packed addresses, slot k at [k*AW +: AW]
- slot_din  in  SLOTS*16  packed write data
- slot_din_m  in  SLOTS*2  packed byte masks, active low per byte
- slot_ack  out  SLOTS  one-cycle pulse when the controller accepts that slot's command
- slot_dst  out  SLOTS  ba_dst routed to the owner
- slot_dok  out  SLOTS  ba_dok routed to the owner
- slot_rdy  out  SLOTS  one-cycle pulse at the owner's ba_rdy
- slot_err  out  SLOTS  one-cycle pulse on watchdog abort
- ba_addr  out  AW  registered address to the controller
- ba_rd, ba_wr  out  1  command strobes
- ba_din  out  16  write data
- ba_din_m  out  2  write mask
- ba_ack, ba_dst, ba_dok, ba_rdy  in  1  controller handshake
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, CMD, WAIT.
- Reset: IDLE; every output is 0, including ba_din_m = 2'b00; round-robin pointer = 0.
- IDLE:
  - If downloading is low and any slot_req is high, grant the first requesting slot at or after the pointer, wrapping modulo SLOTS.
  - On grant, register owner, ba_addr, ba_din, ba_din_m, and ba_rd = ~we or ba_wr = we, then enter CMD.
  - The pointer becomes owner+1 modulo SLOTS.
- CMD:
  - Hold the strobe and all command fields stable until ba_ack.
  - On ba_ack: drop the strobe, pulse slot_ack[owner], clear the watchdog, enter WAIT.
  - If slot_req[owner] falls before ba_ack, the command is still held to ack (the controller cannot be cancelled) and the transaction completes normally.
- WAIT:
  - slot_dst and slot_dok equal ba_dst and ba_dok gated by the one-hot owner; slot data is the controller's sdram_dout, outside this block.
  - On ba_rdy: pulse slot_rdy[owner], go to IDLE.
  - When the watchdog count reaches TOUT: pulse slot_err[owner], go to IDLE.
- ba_ack and ba_rdy in the same cycle in CMD: ack and rdy pulse together and the FSM goes directly to IDLE.
- ba_dst/ba_dok/ba_rdy arriving in IDLE are ignored; all slot_* outputs stay 0.
- downloading rising mid-transaction does not abort it; only IDLE grants are blocked.
- Watchdog counter is $clog2(TOUT+1) bits, saturating, active only in WAIT.

## Timing
- Grant latency: slot_req high at edge n in IDLE -> ba_rd/ba_wr high after edge n+1.
- Minimum transaction: IDLE, CMD, WAIT = 3 cycles. The next grant is issued in the IDLE cycle after slot_rdy, so back-to-back requests issue every ≥3 cycles.
- slot_ack, slot_rdy and slot_err are registered: they are high in the cycle after the triggering ba_ack, ba_rdy or watchdog edge.
- slot_dst and slot_dok are combinational from ba_dst/ba_dok gated by the registered owner, with zero added latency.
- A slot whose request remains high after its slot_rdy is eligible again; round-robin guarantees service within SLOTS transactions.

## Structure
- Shared package jtframe_sdram_pkg:
  - typedef of the state enum {IDLE, CMD, WAIT}.
  - Function for round-robin first-set-at-or-after-pointer.
- Sub-module jtframe_rr_pick (combinational: req vector + pointer -> one-hot grant + index). Reused by the other bank instances.

## Test plan
- Single read: slot 2 req, addr 0x12345, we = 0; ba_ack 2 cycles after ba_rd, ba_rdy 5 cycles later -> ba_rd high for exactly 3 cycles, slot_ack[2] and slot_rdy[2] single pulses, no other slot output toggles.
- Round-robin: all 4 slots request continuously with ack/rdy immediate -> grant order 0,1,2,3,0, one grant every 3 cycles.
- Write: slot 1 we = 1, din 0xBEEF, mask 2'b10 -> ba_wr high, ba_din = 0xBEEF, ba_din_m = 2'b10 stable until ack; ba_rd stays 0.
- Download gating: downloading high with slot 0 requesting -> no ba_rd for 100 cycles; drop downloading -> ba_rd 2 cycles later. Downloading rising in WAIT -> transaction still completes with slot_rdy.
- Watchdog: TOUT = 15, ba_ack given and ba_rdy never given -> slot_err[owner] pulses at 16 cycles after ack, FSM in IDLE, next slot granted.
- Reset mid-WAIT: rst_n low for 1 cycle -> next cycle all outputs 0, busy 0, pointer 0; a subsequent ba_rdy produces no slot_rdy.

Source files
------------

// File: rtl/jtframe_sdram_pkg.sv
// Shared types and helpers for the SDRAM bank-port scheduling blocks.
package jtframe_sdram_pkg;

    localparam int MAX_SLOTS = 8;
    localparam int PTR_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT
    } ba_state_t;

    // Round-robin search: first set bit of req at or after ptr, wrapping at
    // slots. Returns {found, index}. The smallest offset from ptr wins, so the
    // loop walks offsets from the far end down and lets nearer hits overwrite.
    function automatic logic [PTR_W:0] rr_first(
        input logic [MAX_SLOTS-1:0] req,
        input logic [PTR_W-1:0]     ptr,
        input int                   slots
    );
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] k3;
        int               k;
        res = '0;
        for (int o = MAX_SLOTS - 1; o >= 0; o--) begin
            if (o < slots) begin
                k = int'(ptr) + o;
                if (k >= slots) begin
                    k = k - slots;
                end
                k3 = k[PTR_W-1:0];
                if (req[k3]) begin
                    res = {1'b1, k3};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: request vector + pointer -> one-hot grant.
module jtframe_rr_pick
    import jtframe_sdram_pkg::*;
#(
    parameter int SLOTS = 4
) (
    input  logic [SLOTS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [SLOTS-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [MAX_SLOTS-1:0] req_ext;
    logic [PTR_W:0]       pick;

    // Widen the request vector to the fixed width the helper works on.
    always_comb begin
        req_ext             = '0;
        req_ext[SLOTS-1:0]  = req;
    end

    assign pick  = rr_first(req_ext, ptr, SLOTS);
    assign valid = pick[PTR_W];
    assign idx   = pick[PTR_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_gnt
            assign gnt[gi] = valid && (idx == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/jtframe_ba_sched.sv
// Round-robin scheduler sharing one SDRAM bank port among SLOTS requesters.
module jtframe_ba_sched
    import jtframe_sdram_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int TOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS-1:0]    slot_we,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS*16-1:0] slot_din,
    input  logic [SLOTS*2-1:0]  slot_din_m,
    output logic [SLOTS-1:0]    slot_ack,
    output logic [SLOTS-1:0]    slot_dst,
    output logic [SLOTS-1:0]    slot_dok,
    output logic [SLOTS-1:0]    slot_rdy,
    output logic [SLOTS-1:0]    slot_err,
    output logic [AW-1:0]       ba_addr,
    output logic                ba_rd,
    output logic                ba_wr,
    output logic [15:0]         ba_din,
    output logic [1:0]          ba_din_m,
    input  logic                ba_ack,
    input  logic                ba_dst,
    input  logic                ba_dok,
    input  logic                ba_rdy,
    output logic                busy
);

    localparam int WDW = $clog2(TOUT + 1);

    ba_state_t        state_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [SLOTS-1:0] owner_oh_reg;
    logic [WDW-1:0]   wd_reg;
    logic [SLOTS-1:0] slot_ack_reg, slot_rdy_reg, slot_err_reg;
    logic [AW-1:0]    ba_addr_reg;
    logic             ba_rd_reg, ba_wr_reg;
    logic [15:0]      ba_din_reg;
    logic [1:0]       ba_din_m_reg;

    logic [SLOTS-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic [PTR_W-1:0] ptr_next;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [15:0]      sel_din;
    logic [1:0]       sel_din_m;

    jtframe_rr_pick #(
        .SLOTS (SLOTS)
    ) u_pick (
        .req   (slot_req),
        .ptr   (ptr_reg),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign ptr_next = (pick_idx == PTR_W'(SLOTS - 1)) ? '0 : pick_idx + PTR_W'(1);

    // Mux the granted slot's command fields with the one-hot grant.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_din   = '0;
        sel_din_m = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (pick_gnt[k]) begin
                sel_we    = slot_we[k];
                sel_addr  = slot_addr[k*AW +: AW];
                sel_din   = slot_din[k*16 +: 16];
                sel_din_m = slot_din_m[k*2 +: 2];
            end
        end
    end

    // Grant / command / wait FSM with registered strobes and slot pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_oh_reg <= '0;
            wd_reg       <= '0;
            slot_ack_reg <= '0;
            slot_rdy_reg <= '0;
            slot_err_reg <= '0;
            ba_addr_reg  <= '0;
            ba_rd_reg    <= 1'b0;
            ba_wr_reg    <= 1'b0;
            ba_din_reg   <= '0;
            ba_din_m_reg <= 2'b00;
        end else begin
            slot_ack_reg <= '0;
            slot_rdy_reg <= '0;
            slot_err_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (!downloading && pick_valid) begin
                        state_reg    <= CMD;
                        owner_oh_reg <= pick_gnt;
                        ptr_reg      <= ptr_next;
                        ba_addr_reg  <= sel_addr;
                        ba_din_reg   <= sel_din;
                        ba_din_m_reg <= sel_din_m;
                        ba_rd_reg    <= ~sel_we;
                        ba_wr_reg    <= sel_we;
                    end
                end
                CMD: begin
                    // The controller cannot be cancelled: hold until ack even
                    // if the owner withdraws its request.
                    if (ba_ack) begin
                        ba_rd_reg    <= 1'b0;
                        ba_wr_reg    <= 1'b0;
                        slot_ack_reg <= owner_oh_reg;
                        wd_reg       <= '0;
                        if (ba_rdy) begin
                            slot_rdy_reg <= owner_oh_reg;
                            owner_oh_reg <= '0;
                            state_reg    <= IDLE;
                        end else begin
                            state_reg    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ba_rdy) begin
                        slot_rdy_reg <= owner_oh_reg;
                        owner_oh_reg <= '0;
                        state_reg    <= IDLE;
                    end else if (wd_reg == WDW'(TOUT)) begin
                        slot_err_reg <= owner_oh_reg;
                        owner_oh_reg <= '0;
                        state_reg    <= IDLE;
                    end else if (wd_reg != '1) begin
                        wd_reg <= wd_reg + WDW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign slot_ack = slot_ack_reg;
    assign slot_rdy = slot_rdy_reg;
    assign slot_err = slot_err_reg;
    assign slot_dst = owner_oh_reg & {SLOTS{ba_dst}};
    assign slot_dok = owner_oh_reg & {SLOTS{ba_dok}};
    assign ba_addr  = ba_addr_reg;
    assign ba_rd    = ba_rd_reg;
    assign ba_wr    = ba_wr_reg;
    assign ba_din   = ba_din_reg;
    assign ba_din_m = ba_din_m_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_jtframe_ba_sched.sv
// Self-checking bench for jtframe_ba_sched: vector table plus corner sequences.
module tb_jtframe_ba_sched;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int TOUT  = 15;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                downloading = 1'b0;
    logic [SLOTS-1:0]    slot_req = '0;
    logic [SLOTS-1:0]    slot_we = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS*16-1:0] slot_din = '0;
    logic [SLOTS*2-1:0]  slot_din_m = '0;
    logic [SLOTS-1:0]    slot_ack, slot_dst, slot_dok, slot_rdy, slot_err;
    logic [AW-1:0]       ba_addr;
    logic                ba_rd, ba_wr;
    logic [15:0]         ba_din;
    logic [1:0]          ba_din_m;
    logic                ba_ack = 1'b0, ba_dst = 1'b0, ba_dok = 1'b0, ba_rdy = 1'b0;
    logic                busy;

    jtframe_ba_sched #(
        .SLOTS (SLOTS),
        .AW    (AW),
        .TOUT  (TOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .slot_req    (slot_req),
        .slot_we     (slot_we),
        .slot_addr   (slot_addr),
        .slot_din    (slot_din),
        .slot_din_m  (slot_din_m),
        .slot_ack    (slot_ack),
        .slot_dst    (slot_dst),
        .slot_dok    (slot_dok),
        .slot_rdy    (slot_rdy),
        .slot_err    (slot_err),
        .ba_addr     (ba_addr),
        .ba_rd       (ba_rd),
        .ba_wr       (ba_wr),
        .ba_din      (ba_din),
        .ba_din_m    (ba_din_m),
        .ba_ack      (ba_ack),
        .ba_dst      (ba_dst),
        .ba_dok      (ba_dok),
        .ba_rdy      (ba_rdy),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          slot;
        logic        we;
        logic [21:0] addr;
        logic [15:0] din;
        logic [1:0]  dm;
        int          ack_dly;     // strobe cycle index in which ba_ack is given
        int          rdy_dly;     // WAIT cycle index for ba_rdy (-1: with ack)
        int          exp_strobes;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_oh;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic set_slot(input int s, input logic we, input logic [21:0] a,
                            input logic [15:0] d, input logic [1:0] m);
        slot_we[s]             = we;
        slot_addr[s*AW +: AW]  = a;
        slot_din[s*16 +: 16]   = d;
        slot_din_m[s*2 +: 2]   = m;
    endtask

    // Advance until a command strobe is visible, bounded.
    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        tick();
        while (!(ba_rd || ba_wr) && n < 200) begin
            tick();
            n++;
        end
        if (!(ba_rd || ba_wr)) begin
            checks++;
            failures++;
            $display("FAIL %s strobe timeout actual=0 required=1", name);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {1'b0, slot_ack, slot_dst, slot_dok, slot_rdy, slot_err,
                ba_addr, ba_rd, ba_wr, ba_din, ba_din_m, busy};
    endfunction

    initial begin
        vec_t v;
        int rise, ackc, rdyc, n_strobe, n_ack, n_rdy, ack_at, rdy_at;
        logic bad, dst_bad;
        logic [3:0] ack_or, rdy_or, err_or;
        int order[5];
        int when[5];
        int ngr, n, err_at;
        logic [3:0] err_val;
        logic [3:0] exp_order[5];

        vecs[0] = '{slot:2, we:1'b0, addr:22'h012345, din:16'h0000, dm:2'b00,
                    ack_dly:2, rdy_dly:4, exp_strobes:3, exp_rd:1'b1, exp_wr:1'b0, exp_oh:4'b0100};
        vecs[1] = '{slot:1, we:1'b1, addr:22'h3FFFFF, din:16'hBEEF, dm:2'b10,
                    ack_dly:3, rdy_dly:0, exp_strobes:4, exp_rd:1'b0, exp_wr:1'b1, exp_oh:4'b0010};
        vecs[2] = '{slot:0, we:1'b0, addr:22'h000000, din:16'h5A5A, dm:2'b11,
                    ack_dly:0, rdy_dly:-1, exp_strobes:1, exp_rd:1'b1, exp_wr:1'b0, exp_oh:4'b0001};
        vecs[3] = '{slot:3, we:1'b1, addr:22'h2AAAAA, din:16'h1234, dm:2'b01,
                    ack_dly:1, rdy_dly:2, exp_strobes:2, exp_rd:1'b0, exp_wr:1'b1, exp_oh:4'b1000};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 64'h0);
        rst_n = 1'b1;
        tick();

        // Table-driven single transactions
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            set_slot(v.slot, v.we, v.addr, v.din, v.dm);
            slot_req[v.slot] = 1'b1;
            rise = -1; ackc = -1; rdyc = -1;
            n_strobe = 0; n_ack = 0; n_rdy = 0; ack_at = -1; rdy_at = -1;
            bad = 1'b0; dst_bad = 1'b0;
            ack_or = '0; rdy_or = '0; err_or = '0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                tick();
                if (ba_rd || ba_wr) begin
                    n_strobe++;
                    if (rise < 0) rise = cyc;
                    if ({ba_rd, ba_wr, ba_addr, ba_din, ba_din_m} !==
                        {v.exp_rd, v.exp_wr, v.addr, v.din, v.dm}) bad = 1'b1;
                end
                if (slot_ack != 0) begin ack_or |= slot_ack; n_ack++; ack_at = cyc; end
                if (slot_rdy != 0) begin rdy_or |= slot_rdy; n_rdy++; rdy_at = cyc; end
                err_or |= slot_err;
                if (slot_rdy != 0) slot_req[v.slot] = 1'b0;
                ba_ack = (rise >= 0 && ackc < 0 && (cyc - rise) == v.ack_dly);
                if (ba_ack) ackc = cyc;
                ba_rdy = (ackc >= 0 && rdyc < 0 && cyc == ackc + 1 + v.rdy_dly);
                if (ba_rdy) rdyc = cyc;
                ba_dst = ba_rdy;
                ba_dok = ba_rdy;
                #1;
                if (ba_dst && (slot_dst !== v.exp_oh || slot_dok !== v.exp_oh)) dst_bad = 1'b1;
            end
            ba_ack = 1'b0; ba_rdy = 1'b0; ba_dst = 1'b0; ba_dok = 1'b0;
            slot_req = '0;
            chk($sformatf("v%0d_strobe_cycles", i), 64'(n_strobe), 64'(v.exp_strobes));
            chk($sformatf("v%0d_cmd_fields", i), 64'(bad), 64'h0);
            chk($sformatf("v%0d_ack_oh", i), 64'(ack_or), 64'(v.exp_oh));
            chk($sformatf("v%0d_ack_count", i), 64'(n_ack), 64'd1);
            chk($sformatf("v%0d_ack_latency", i), 64'(ack_at - ackc), 64'd1);
            chk($sformatf("v%0d_rdy_oh", i), 64'(rdy_or), 64'(v.exp_oh));
            chk($sformatf("v%0d_rdy_count", i), 64'(n_rdy), 64'd1);
            chk($sformatf("v%0d_rdy_latency", i), 64'(rdy_at - rdyc), 64'd1);
            chk($sformatf("v%0d_err_none", i), 64'(err_or), 64'h0);
            chk($sformatf("v%0d_dst_route", i), 64'(dst_bad), 64'h0);
            chk($sformatf("v%0d_busy_end", i), 64'(busy), 64'h0);
        end

        // Round-robin with immediate ack/rdy; pointer is 0 after slot 3 above
        for (int k = 0; k < SLOTS; k++) set_slot(k, 1'b0, 22'h000100 + 22'(k), 16'h0, 2'b00);
        slot_req = '1;
        ngr = 0;
        for (int cyc = 0; cyc < 60 && ngr < 5; cyc++) begin
            tick();
            if (ba_rd || ba_wr) begin
                order[ngr] = int'(ba_addr - 22'h000100);
                when[ngr]  = cyc;
                ngr++;
            end
            ba_ack = ba_rd | ba_wr;
            ba_rdy = |slot_ack;
        end
        slot_req = '0;
        repeat (6) begin
            tick();
            ba_ack = ba_rd | ba_wr;
            ba_rdy = |slot_ack;
        end
        ba_ack = 1'b0; ba_rdy = 1'b0;
        chk("rr_grants", 64'(ngr), 64'd5);
        exp_order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(exp_order[k]));
        for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), 64'(when[k] - when[k-1]), 64'd3);
        chk("rr_idle", 64'(busy), 64'h0);

        // Download gating, and downloading rising inside WAIT
        downloading = 1'b1;
        set_slot(0, 1'b0, 22'h000ABC, 16'h0, 2'b00);
        slot_req = 4'b0001;
        n = 0;
        repeat (100) begin
            tick();
            if (ba_rd || ba_wr) n++;
        end
        chk("dl_block", 64'(n), 64'h0);
        downloading = 1'b0;
        tick();
        chk("dl_release_rd", {ba_rd, ba_addr}, {1'b1, 22'h000ABC});
        ba_ack = 1'b1;
        tick();
        ba_ack = 1'b0;
        chk("dl_ack", 64'(slot_ack), 64'h1);
        downloading = 1'b1;
        tick();
        tick();
        ba_rdy = 1'b1;
        tick();
        ba_rdy = 1'b0;
        chk("dl_rdy_mid", 64'(slot_rdy), 64'h1);
        slot_req = '0;
        downloading = 1'b0;
        tick();
        chk("dl_idle", 64'(busy), 64'h0);

        // Watchdog: pointer is 1, slots 1 and 2 request, no ba_rdy for slot 1
        set_slot(1, 1'b0, 22'h000111, 16'h0, 2'b00);
        set_slot(2, 1'b0, 22'h000222, 16'h0, 2'b00);
        slot_req = 4'b0110;
        wait_strobe("wd_grant");
        chk("wd_grant_addr", 64'(ba_addr), 64'h111);
        ba_ack = 1'b1;
        tick();
        ba_ack = 1'b0;
        err_at = -1;
        err_val = '0;
        for (int k = 1; k <= 40 && err_at < 0; k++) begin
            tick();
            if (slot_err != 0) begin
                err_at = k;
                err_val = slot_err;
            end
        end
        chk("wd_latency", 64'(err_at), 64'd16);
        chk("wd_err_oh", 64'(err_val), 64'h2);
        chk("wd_idle", 64'(busy), 64'h0);
        slot_req[1] = 1'b0;
        tick();
        chk("wd_next_grant", {ba_rd, ba_addr}, {1'b1, 22'h000222});
        ba_ack = 1'b1;
        tick();
        ba_ack = 1'b0;
        ba_rdy = 1'b1;
        tick();
        ba_rdy = 1'b0;
        slot_req = '0;
        tick();

        // Reset in WAIT: pointer would be 2 afterwards without the reset
        set_slot(1, 1'b0, 22'h000111, 16'h0, 2'b00);
        slot_req = 4'b0010;
        wait_strobe("rst_grant");
        ba_ack = 1'b1;
        tick();
        ba_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        slot_req = '0;
        tick();
        rst_n = 1'b1;
        chk("rst_outputs", all_outs(), 64'h0);
        ba_rdy = 1'b1;
        ba_dst = 1'b1;
        ba_dok = 1'b1;
        #1;
        chk("idle_dst_ignored", {slot_dst, slot_dok}, 64'h0);
        tick();
        ba_rdy = 1'b0;
        ba_dst = 1'b0;
        ba_dok = 1'b0;
        chk("rst_no_rdy", {slot_rdy, slot_ack, slot_err, 3'b000, busy}, 64'h0);
        set_slot(0, 1'b0, 22'h0000A0, 16'h0, 2'b00);
        set_slot(3, 1'b0, 22'h0003A3, 16'h0, 2'b00);
        slot_req = 4'b1001;
        wait_strobe("rst_ptr");
        chk("rst_ptr_grant", 64'(ba_addr), 64'h0A0);
        ba_ack = 1'b1;
        ba_rdy = 1'b1;
        tick();
        ba_ack = 1'b0;
        ba_rdy = 1'b0;
        slot_req = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
